// File: rtl/parity_stream_gen.sv
// parity_stream_gen: streaming per-word and per-frame parity generator with
// valid/ready handshake on both sides and a single registered output stage.
// Optional feature macro: PARITY_CHECK_EN adds in_par_exp, par_err and err_cnt
// (compare incoming parity against the generated value, saturating count).
module parity_stream_gen #(
   parameter  int unsigned DATA_W    = 8,
   parameter  int unsigned MAX_BEATS = 16,
   localparam int unsigned CNT_W     = $clog2(MAX_BEATS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              odd_mode,
`ifdef PARITY_CHECK_EN
   input  logic              in_par_exp,
   output logic              par_err,
   output logic [7:0]        err_cnt,
`endif
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_par,
   output logic              out_last,
   output logic              frame_par,
   output logic              frame_err,
   output logic [CNT_W-1:0]  beat_idx
);

   typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

   state_t              r_state;
   logic                r_mode;
   logic [DATA_W-1:0]   r_acc;
   logic [CNT_W-1:0]    r_cnt;

   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic                r_out_par;
   logic                r_out_last;
   logic                r_frame_par;
   logic                r_frame_err;
   logic [CNT_W-1:0]    r_beat_idx;

   logic                w_accept;
   logic                w_mode;
   logic                w_word_par;
   logic [DATA_W-1:0]   w_acc_next;
   logic                w_forced;
   logic                w_last;

   // Handshake, mode selection and parity terms for the beat being offered.
   // In IDLE the mode is taken live from odd_mode (first beat latches it).
   always_comb begin
      in_ready   = !r_out_valid || out_ready;
      w_accept   = in_valid && in_ready;
      w_mode     = (r_state == S_IDLE) ? odd_mode : r_mode;
      w_word_par = (^in_data) ^ w_mode;
      w_acc_next = r_acc ^ in_data;
      w_forced   = (r_cnt == CNT_W'(MAX_BEATS - 1));
      w_last     = in_last || w_forced;
   end

   // Frame FSM, accumulator, beat counter and registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mode      <= 1'b0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_par   <= 1'b0;
         r_out_last  <= 1'b0;
         r_frame_par <= 1'b0;
         r_frame_err <= 1'b0;
         r_beat_idx  <= '0;
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data;
            r_out_par   <= w_word_par;
            r_out_last  <= w_last;
            r_frame_par <= w_last ? ((^w_acc_next) ^ w_mode) : 1'b0;
            r_frame_err <= w_forced && !in_last;
            r_beat_idx  <= r_cnt;
            r_mode      <= w_mode;
            if (w_last) begin
               r_state <= S_IDLE;
               r_acc   <= '0;
               r_cnt   <= '0;
            end else begin
               r_state <= S_ACTIVE;
               r_acc   <= w_acc_next;
               r_cnt   <= r_cnt + CNT_W'(1);
            end
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

`ifdef PARITY_CHECK_EN
   logic       r_par_err;
   logic [7:0] r_err_cnt;

   // Compare expected parity with the generated one; saturating error count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par_err <= 1'b0;
         r_err_cnt <= '0;
      end else if (w_accept) begin
         r_par_err <= (in_par_exp != w_word_par);
         if ((in_par_exp != w_word_par) && (r_err_cnt != 8'hFF))
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign par_err = r_par_err;
   assign err_cnt = r_err_cnt;
`endif

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_par   = r_out_par;
   assign out_last  = r_out_last;
   assign frame_par = r_frame_par;
   assign frame_err = r_frame_err;
   assign beat_idx  = r_beat_idx;

endmodule

// File: tb/tb_parity_stream_gen.sv
// Scoreboard bench for parity_stream_gen (DATA_W=8, MAX_BEATS=4).
// Driver pushes hand-computed expectations; monitor pops on output handshake.
module tb_parity_stream_gen;

   localparam int unsigned DW = 8;
   localparam int unsigned MB = 4;
   localparam int unsigned CW = $clog2(MB);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          odd_mode = 1'b0;
   logic          in_par_exp = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_par;
   logic          out_last;
   logic          frame_par;
   logic          frame_err;
   logic [CW-1:0] beat_idx;
`ifdef PARITY_CHECK_EN
   logic          par_err;
   logic [7:0]    err_cnt;
`endif

   typedef struct {
      logic [DW-1:0] data;
      logic          par;
      logic          last;
      logic          fpar;
      logic          ferr;
      logic [CW-1:0] idx;
      logic          perr;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   parity_stream_gen #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .odd_mode(odd_mode),
`ifdef PARITY_CHECK_EN
      .in_par_exp(in_par_exp), .par_err(par_err), .err_cnt(err_cnt),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_par(out_par), .out_last(out_last), .frame_par(frame_par),
      .frame_err(frame_err), .beat_idx(beat_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Offer one word; on acceptance push its expected output into the scoreboard.
   task automatic send(input logic [DW-1:0] d, input logic l, input logic m,
                       input logic pe, input logic e_par, input logic e_last,
                       input logic e_fpar, input logic e_ferr,
                       input logic [CW-1:0] e_idx, input logic e_perr);
      exp_t e;
      bit   ok = 0;
      in_data = d; in_last = l; odd_mode = m; in_par_exp = pe; in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         n_vec++; n_err++;
         $display("FAIL accept_timeout: in_ready stuck 0 for data %0h", d);
      end else begin
         e.data = d; e.par = e_par; e.last = e_last; e.fpar = e_fpar;
         e.ferr = e_ferr; e.idx = e_idx; e.perr = e_perr;
         q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Monitor: compare each output beat taken by the downstream side.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_output: data %0h with empty scoreboard", out_data);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_par",  32'(out_par),  32'(e.par));
            chk("out_last", 32'(out_last), 32'(e.last));
            chk("beat_idx", 32'(beat_idx), 32'(e.idx));
            chk("frame_err", 32'(frame_err), 32'(e.ferr));
            if (e.last) chk("frame_par", 32'(frame_par), 32'(e.fpar));
`ifdef PARITY_CHECK_EN
            chk("par_err", 32'(par_err), 32'(e.perr));
`endif
         end
      end
   end

   task automatic chk_reset_state(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_data"},  32'(out_data),  32'd0);
      chk({tag, "_out_par"},   32'(out_par),   32'd0);
      chk({tag, "_out_last"},  32'(out_last),  32'd0);
      chk({tag, "_frame_par"}, 32'(frame_par), 32'd0);
      chk({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      chk({tag, "_beat_idx"},  32'(beat_idx),  32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
`ifdef PARITY_CHECK_EN
      chk({tag, "_par_err"},   32'(par_err),   32'd0);
      chk({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
`endif
   endtask

   initial begin
      bit drained;
      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single beat, even: A5 has 4 ones.
      send(8'hA5, 1, 0, 0,  0, 1, 0, 0, 0, 0);
      // Frame A5,01,03 even: acc=A7 (5 ones) -> frame_par 1.
      send(8'hA5, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      send(8'h01, 0, 0, 1,  1, 0, 0, 0, 1, 0);
      send(8'h03, 1, 0, 0,  0, 1, 1, 0, 2, 0);
      // Same frame in odd mode.
      send(8'hA5, 0, 1, 1,  1, 0, 0, 0, 0, 0);
      send(8'h01, 0, 1, 0,  0, 0, 0, 0, 1, 0);
      send(8'h03, 1, 1, 1,  1, 1, 0, 0, 2, 0);
      // Mode latched even on beat 0; odd_mode=1 later is ignored.
      send(8'hA5, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      send(8'h01, 0, 1, 1,  1, 0, 0, 0, 1, 0);
      send(8'h03, 1, 1, 0,  0, 1, 1, 0, 2, 0);

      // Backpressure: 3C held while out_ready=0, then 07 follows with no bubble.
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(8'h3C, 1, 0, 0,  0, 1, 0, 0, 0, 0);
      fork
         send(8'h07, 1, 0, 1,  1, 1, 1, 0, 0, 0);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("stall_in_ready", 32'(in_ready), 32'd0);
               chk("stall_out_data", 32'(out_data), 32'h3C);
               chk("stall_out_valid", 32'(out_valid), 32'd1);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join

      // Forced termination at MAX_BEATS=4, odd mode: acc=FF -> frame_par 1.
      send(8'h11, 0, 1, 1,  1, 0, 0, 0, 0, 0);
      send(8'h22, 0, 1, 1,  1, 0, 0, 0, 1, 0);
      send(8'h44, 0, 1, 1,  1, 0, 0, 0, 2, 0);
      send(8'h88, 0, 1, 1,  1, 1, 1, 1, 3, 0);
      // Fifth beat starts a new frame with freshly latched even mode.
      send(8'h0F, 0, 0, 0,  0, 0, 0, 0, 0, 0);
      send(8'h01, 1, 1, 1,  1, 1, 1, 0, 1, 0);

      // Mid-frame reset; with the checker, 01 carries a wrong expected parity.
      send(8'h01, 0, 0, 0,  1, 0, 0, 0, 0, 1);
`ifdef PARITY_CHECK_EN
      @(negedge clk);
      chk("err_cnt_after_err", 32'(err_cnt), 32'd1);
`endif
      @(posedge clk); #1;
      out_ready = 1'b0;
      send(8'h20, 0, 0, 1,  1, 0, 0, 0, 1, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      q.delete();
      chk_reset_state("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      // First beat after reset is beat 0: 05 has 2 ones.
      send(8'h05, 1, 0, 0,  0, 1, 0, 0, 0, 0);

      drained = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (q.size() == 0) begin drained = 1; break; end
      end
      if (!drained) begin
         n_vec++; n_err++;
         $display("FAIL drain_timeout: %0d beats still expected, 0 required", q.size());
      end
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/parity_stream_gen.md
# parity_stream_gen

Streaming, parametrised parity generator for multi-beat frames of DATA_W-bit words, with a valid/ready handshake on both sides. It produces per-word parity and an accumulated frame parity, in even or odd mode. It sits between a word source and a serialiser/link layer and replaces fixed-width combinational parity on the datapath. An optional checker compares incoming parity against the generated value and counts mismatches.

## Interface
- DATA_W, 8, word width in bits (≥1)
- MAX_BEATS, 16, maximum beats per frame (≥2); frame is force-terminated at this length
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  DATA_W  input word
- in_last  input  1  final word of frame
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on first beat of frame
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts output
- out_data  output  DATA_W  registered copy of accepted word
- out_par  output  1  parity of out_data under the frame's latched mode
- out_last  output  1  final beat of frame (in_last or forced)
- frame_par  output  1  parity over all words of the frame; meaningful only when out_last=1
- frame_err  output  1  frame truncated at MAX_BEATS without in_last; valid with out_last
- beat_idx  output  $clog2(MAX_BEATS)  zero-based beat index of out_data within its frame

## Operation
- Input accept: in_valid && in_ready. in_ready = !out_valid || out_ready, so the output register is a single stage with no skid buffer.
- Per-word parity: out_par = ^in_data ^ mode_q, where mode_q is odd_mode latched on the first beat of the frame.
- odd_mode changes after the first beat of a frame are ignored until the next frame.
- Frame accumulator acc (DATA_W bits) updates on accept: acc_next = acc ^ in_data. It clears after the last beat.
- frame_par = ^(acc ^ in_data) ^ mode_q, registered with the last beat.
- Beat counter counts accepted beats from 0. On the last beat (in_last, or count = MAX_BEATS-1) the counter and acc clear and the frame state returns to IDLE.
- Forced termination: beat MAX_BEATS-1 accepted with in_last=0 gives out_last=1 and frame_err=1. The next input beat starts a new frame.
- Frame states: IDLE (no beat yet, mode not latched) → ACTIVE (on first accept with in_last=0) → IDLE (on last accept). A single-beat frame (in_last on first beat) stays in IDLE.
- Output holds stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 word/cycle when out_ready is held at 1.
- Simultaneous output accept and new input accept in the same cycle: the output register loads the new word, with no bubble.
- Reset values: out_valid=0, out_data=0, out_par=0, out_last=0, frame_par=0, frame_err=0, beat_idx=0, in_ready=1 (combinational from out_valid=0).
- Internal reset values: acc=0, counter=0, state IDLE, mode_q=0.
- Reset asserted mid-frame discards the partial frame. The first accept after reset is beat 0 of a new frame.

## Configuration
- PARITY_CHECK_EN defined: adds the following ports.
  - in_par_exp  input  1  expected parity, sampled with in_data
  - par_err  output  1  registered with the output beat; 1 when in_par_exp differs from the generated per-word parity
  - err_cnt  output  8  saturating count of par_err beats, reset 0, holds at 255
- PARITY_CHECK_EN undefined: these ports and their logic are absent. Generation behaviour is unchanged.

## Test plan
- DATA_W=8, even mode, single beat 8'hA5 with in_last=1 → one cycle later: out_data=A5, out_par=0, out_last=1, frame_par=0, frame_err=0.
- Frame A5, 01, 03 (last on 03), even mode → out_par sequence 0, 1, 0; frame_par=1 on beat 2; beat_idx 0, 1, 2. Same frame in odd mode → out_par sequence 1, 0, 1; frame_par=0.
- Set odd_mode=0 on beat 0, then toggle it to 1 on beats 1–2 → all out_par values computed as even; mode change ignored mid-frame.
- out_ready held low 3 cycles with a word pending → in_ready=0 and out_data stable. Release out_ready → next word appears the following cycle with no loss or duplication.
- MAX_BEATS=4, send 5 beats with in_last=0 throughout → beat_idx=3 carries out_last=1 and frame_err=1; the 5th beat appears with beat_idx=0 and a freshly latched mode.
- PARITY_CHECK_EN: word 8'h01 with in_par_exp=0 in even mode → par_err=1 and err_cnt increments to 1. Assert rst_n low mid-frame → all outputs return to reset values and err_cnt=0.
